// File: rtl/wb_arb_pkg.sv
// Shared types and sizing helpers for the wb_arb Wishbone arbiter.
package wb_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Width of the outstanding-strobe counter: $clog2(MAX_OUT+1).
    function automatic int out_cnt_w(input int max_out);
        return (max_out < 1) ? 1 : $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/wb_arb_rr.sv
// Combinational round-robin picker: the first requester at or after ptr
// (wrapping) wins; the result is one-hot, or zero when nobody requests.
import wb_arb_pkg::*;

module wb_arb_rr #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    // Two scans: indices from ptr upward first, then the wrapped low part
    always_comb begin
        logic found;
        gnt   = {N{1'b0}};
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && (i >= int'(ptr)) && req[i]) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end else begin
                found = found;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && (i < int'(ptr)) && req[i]) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/wb_arb.sv
// Round-robin arbiter giving N_MST pipelined Wishbone masters access to one
// shared slave. Optional ack watchdog enabled by defining WB_ARB_TIMEOUT_EN.
import wb_arb_pkg::*;

module wb_arb #(
    parameter int CFGAW   = 32,
    parameter int CFGDW   = 32,
    parameter int N_MST   = 2,
    parameter int MAX_OUT = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_MST-1:0]             m_cyc_i,
    input  logic [N_MST-1:0]             m_stb_i,
    input  logic [N_MST-1:0]             m_we_i,
    input  logic [N_MST-1:0][CFGAW-1:0]  m_addr_i,
    input  logic [N_MST-1:0][CFGDW-1:0]  m_data_i,
    output logic [N_MST-1:0]             m_ack_o,
    output logic [N_MST-1:0]             m_stall_o,
    output logic [N_MST-1:0]             m_err_o,
    output logic [CFGDW-1:0]             m_data_o,
    output logic                         s_cyc_o,
    output logic                         s_stb_o,
    output logic                         s_we_o,
    output logic [CFGAW-1:0]             s_addr_o,
    output logic [CFGDW-1:0]             s_data_o,
    input  logic                         s_ack_i,
    input  logic                         s_stall_i,
    input  logic [CFGDW-1:0]             s_data_i,
    output logic [N_MST-1:0]             grant_o,
    output logic                         busy_o
);

    localparam int PW = (N_MST > 1) ? $clog2(N_MST) : 1;
    localparam int OW = out_cnt_w(MAX_OUT);

    // Elaboration-time parameter legality
    if (N_MST < 2 || N_MST > 8) begin : g_bad_nmst
        $error("wb_arb: N_MST out of range 2..8");
    end
    if (MAX_OUT < 1 || MAX_OUT > 15) begin : g_bad_maxout
        $error("wb_arb: MAX_OUT out of range 1..15");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("wb_arb: TIMEOUT must be positive");
    end

    arb_state_e        state_r, state_nxt_s;
    logic [N_MST-1:0]  grant_nxt_s, win_s;
    logic [PW-1:0]     ptr_r, ptr_nxt_s, widx_s;
    logic [OW-1:0]     out_cnt_r;
    logic              cyc_g_s, stb_g_s, full_s, timeout_hit_s;
    logic              inc_s, dec_s;

    function automatic logic [PW-1:0] oh2idx(input logic [N_MST-1:0] oh);
        logic [PW-1:0] idx;
        idx = {PW{1'b0}};
        for (int i = 0; i < N_MST; i++) begin
            if (oh[i]) idx = idx | PW'(i);
            else       idx = idx;
        end
        return idx;
    endfunction

    wb_arb_rr #(.N(N_MST), .PW(PW)) u_rr (
        .req (m_cyc_i),
        .ptr (ptr_r),
        .gnt (win_s)
    );

    assign widx_s = oh2idx(win_s);

    // Mux the granted master onto the slave side (grant_o is zero in IDLE)
    always_comb begin
        cyc_g_s  = 1'b0;
        stb_g_s  = 1'b0;
        s_we_o   = 1'b0;
        s_addr_o = {CFGAW{1'b0}};
        s_data_o = {CFGDW{1'b0}};
        for (int i = 0; i < N_MST; i++) begin
            if (grant_o[i]) begin
                cyc_g_s  = cyc_g_s | m_cyc_i[i];
                stb_g_s  = stb_g_s | m_stb_i[i];
                s_we_o   = s_we_o | m_we_i[i];
                s_addr_o = s_addr_o | m_addr_i[i];
                s_data_o = s_data_o | m_data_i[i];
            end else begin
                cyc_g_s = cyc_g_s;
            end
        end
    end

    // Full only when the limit is reached and no ack frees a slot this cycle
    assign full_s    = (out_cnt_r == OW'(MAX_OUT)) && !s_ack_i;
    assign s_cyc_o   = cyc_g_s && !timeout_hit_s;
    assign s_stb_o   = s_cyc_o && stb_g_s && !full_s;
    assign m_stall_o = ~grant_o | {N_MST{s_stall_i | full_s | timeout_hit_s}};
    // Acks reach the master only while its cycle is live and work is pending
    assign m_ack_o   = grant_o & {N_MST{s_ack_i && s_cyc_o && (out_cnt_r != {OW{1'b0}})}};
    assign m_data_o  = s_data_i;
    assign busy_o    = (state_r == ST_GRANT);
    assign inc_s     = s_stb_o && !s_stall_i;
    assign dec_s     = s_ack_i && (out_cnt_r != {OW{1'b0}});

    // Next-state, next-grant and round-robin pointer update
    always_comb begin
        state_nxt_s = state_r;
        grant_nxt_s = grant_o;
        ptr_nxt_s   = ptr_r;
        case (state_r)
            ST_IDLE: begin
                if (|m_cyc_i) begin
                    state_nxt_s = ST_GRANT;
                    grant_nxt_s = win_s;
                    ptr_nxt_s   = (widx_s == PW'(N_MST - 1)) ? {PW{1'b0}} : (widx_s + PW'(1));
                end else begin
                    grant_nxt_s = {N_MST{1'b0}};
                end
            end
            ST_GRANT: begin
                if (!cyc_g_s || timeout_hit_s) begin
                    state_nxt_s = ST_IDLE;
                    grant_nxt_s = {N_MST{1'b0}};
                end else begin
                    state_nxt_s = ST_GRANT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                grant_nxt_s = {N_MST{1'b0}};
            end
        endcase
    end

    // FSM state, registered grant and pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            grant_o <= {N_MST{1'b0}};
            ptr_r   <= {PW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            grant_o <= grant_nxt_s;
            ptr_r   <= ptr_nxt_s;
        end
    end

    // Outstanding strobe counter, cleared whenever GRANT is not held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cnt_r <= {OW{1'b0}};
        end else if ((state_r != ST_GRANT) || (state_nxt_s != ST_GRANT)) begin
            out_cnt_r <= {OW{1'b0}};
        end else begin
            case ({inc_s, dec_s})
                2'b10:   out_cnt_r <= out_cnt_r + OW'(1);
                2'b01:   out_cnt_r <= out_cnt_r - OW'(1);
                default: out_cnt_r <= out_cnt_r;
            endcase
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] to_cnt_r;

    assign timeout_hit_s = (state_r == ST_GRANT) && (to_cnt_r == TW'(TIMEOUT));
    assign m_err_o       = grant_o & {N_MST{timeout_hit_s}};

    // Ack watchdog: counts stalled cycles with work pending, any ack clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_r <= {TW{1'b0}};
        end else if ((state_r != ST_GRANT) || s_ack_i || timeout_hit_s) begin
            to_cnt_r <= {TW{1'b0}};
        end else if (out_cnt_r != {OW{1'b0}}) begin
            to_cnt_r <= to_cnt_r + TW'(1);
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end
`else
    assign timeout_hit_s = 1'b0;
    assign m_err_o       = {N_MST{1'b0}};
`endif

endmodule
